// File: rtl/battleship_pkg.sv
// Shared types and the cursor adjacency table for the 4-digit, 28-segment battleship board.
package battleship_pkg;

  typedef enum logic [2:0] {SegA, SegB, SegC, SegD, SegE, SegF, SegG} seg_t;
  typedef enum logic [1:0] {StPlace = 2'd0, StReady = 2'd1, StLocked = 2'd2} game_state_t;
  typedef enum logic [1:0] {DirUp, DirDown, DirLeft, DirRight} dir_t;

  localparam int unsigned NumCells = 28;

  // Returns {sector, pos}. Sector arithmetic is 2-bit so it wraps around the board.
  function automatic logic [4:0] nav_next(input logic [1:0] sector, input seg_t pos,
                                          input dir_t dir);
    logic [1:0] sec_n;
    seg_t       pos_n;
    sec_n = sector;
    pos_n = pos;
    unique case (dir)
      DirUp: begin
        case (pos)
          SegD:    pos_n = SegG;
          SegG:    pos_n = SegA;
          SegA:    pos_n = SegD;
          SegC:    pos_n = SegB;
          SegB:    pos_n = SegC;
          SegE:    pos_n = SegF;
          SegF:    pos_n = SegE;
          default: pos_n = pos;
        endcase
      end
      DirDown: begin
        case (pos)
          SegA:    pos_n = SegG;
          SegG:    pos_n = SegD;
          SegD:    pos_n = SegA;
          SegB:    pos_n = SegC;
          SegC:    pos_n = SegB;
          SegF:    pos_n = SegE;
          SegE:    pos_n = SegF;
          default: pos_n = pos;
        endcase
      end
      DirLeft: begin
        case (pos)
          SegB:    pos_n = SegF;
          SegC:    pos_n = SegE;
          SegF: begin
            pos_n = SegB;
            sec_n = sector + 2'd1;
          end
          SegE: begin
            pos_n = SegC;
            sec_n = sector + 2'd1;
          end
          default: sec_n = sector + 2'd1;
        endcase
      end
      DirRight: begin
        case (pos)
          SegF:    pos_n = SegB;
          SegE:    pos_n = SegC;
          SegB: begin
            pos_n = SegF;
            sec_n = sector - 2'd1;
          end
          SegC: begin
            pos_n = SegE;
            sec_n = sector - 2'd1;
          end
          default: sec_n = sector - 2'd1;
        endcase
      end
    endcase
    return {sec_n, pos_n};
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// One push-button: 2-flop synchroniser, counter debounce, rising-edge one-shot.
module btn_conditioner #(
  parameter int unsigned DebounceCycles = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned CntW = (DebounceCycles > 2) ? $clog2(DebounceCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            pulse_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= level_d & ~level_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/battleship_cursor_ctrl.sv
// Cursor, ship/shot maps and placement/lock/fire FSM for the battleship board.
module battleship_cursor_ctrl
  import battleship_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned MAX_SHIPS       = 5,
  parameter int unsigned BLINK_CYCLES    = 12500000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dup,
  input  logic                ddown,
  input  logic                dleft,
  input  logic                dright,
  input  logic                dok,
  output logic [1:0]          cur_sector,
  output logic [2:0]          cur_pos,
  output logic                cursor_vis,
  output logic [NumCells-1:0] ships,
  output logic [NumCells-1:0] shots,
  output logic [4:0]          ship_count,
  output logic [1:0]          state,
  output logic                fire_valid,
  output logic [4:0]          fire_index
);

  localparam int unsigned BlinkW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_CYCLES - 1);
  localparam logic [4:0] MaxShips = 5'(MAX_SHIPS);

  logic [4:0] raw, pulse;
  assign raw = {dok, dright, dleft, ddown, dup};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_conditioner #(
      .DebounceCycles(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (raw[i]),
      .pulse(pulse[i])
    );
  end

  logic                nav_en, ok_en;
  dir_t                nav_dir;
  logic [4:0]          nav_res;
  logic [1:0]          sector_q, sector_d;
  seg_t                pos_q, pos_d;
  logic [4:0]          cur_idx;
  game_state_t         state_q, state_d;
  logic [NumCells-1:0] ships_q, ships_d, shots_q, shots_d;
  logic [4:0]          count_q, count_d;
  logic                fire_valid_q, fire_valid_d;
  logic [4:0]          fire_index_q, fire_index_d;
  logic [BlinkW-1:0]   blink_q, blink_d;
  logic                vis_q, vis_d;

  // Fixed priority up > down > left > right > ok; losers are dropped.
  always_comb begin
    nav_en  = 1'b0;
    nav_dir = DirUp;
    ok_en   = 1'b0;
    if (pulse[0]) begin
      nav_en = 1'b1;
    end else if (pulse[1]) begin
      nav_en  = 1'b1;
      nav_dir = DirDown;
    end else if (pulse[2]) begin
      nav_en  = 1'b1;
      nav_dir = DirLeft;
    end else if (pulse[3]) begin
      nav_en  = 1'b1;
      nav_dir = DirRight;
    end else if (pulse[4]) begin
      ok_en = 1'b1;
    end
  end

  assign nav_res = nav_next(sector_q, pos_q, nav_dir);
  assign cur_idx = {3'b000, sector_q} * 5'd7 + {2'b00, pos_q};

  always_comb begin
    sector_d = sector_q;
    pos_d    = pos_q;
    blink_d  = blink_q;
    vis_d    = vis_q;
    if (nav_en) begin
      sector_d = nav_res[4:3];
      pos_d    = seg_t'(nav_res[2:0]);
      blink_d  = '0;
      vis_d    = 1'b1;
    end else if (blink_q == BlinkMax) begin
      blink_d = '0;
      vis_d   = ~vis_q;
    end else begin
      blink_d = blink_q + BlinkW'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    ships_d      = ships_q;
    shots_d      = shots_q;
    count_d      = count_q;
    fire_valid_d = 1'b0;
    fire_index_d = fire_index_q;
    if (ok_en) begin
      case (state_q)
        StPlace: begin
          if (ships_q[cur_idx]) begin
            ships_d[cur_idx] = 1'b0;
            if (count_q != 5'd0) count_d = count_q - 5'd1;
          end else if (count_q < MaxShips) begin
            ships_d[cur_idx] = 1'b1;
            count_d          = count_q + 5'd1;
            if (count_d == MaxShips) state_d = StReady;
          end
        end
        StReady: begin
          if (ships_q[cur_idx]) begin
            ships_d[cur_idx] = 1'b0;
            count_d          = count_q - 5'd1;
            state_d          = StPlace;
          end else begin
            state_d = StLocked;
          end
        end
        StLocked: begin
          if (!shots_q[cur_idx]) begin
            shots_d[cur_idx] = 1'b1;
            fire_valid_d     = 1'b1;
            fire_index_d     = cur_idx;
          end
        end
        default: state_d = StPlace;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sector_q     <= 2'd0;
      pos_q        <= SegA;
      state_q      <= StPlace;
      ships_q      <= '0;
      shots_q      <= '0;
      count_q      <= 5'd0;
      fire_valid_q <= 1'b0;
      fire_index_q <= 5'd0;
      blink_q      <= '0;
      vis_q        <= 1'b1;
    end else begin
      sector_q     <= sector_d;
      pos_q        <= pos_d;
      state_q      <= state_d;
      ships_q      <= ships_d;
      shots_q      <= shots_d;
      count_q      <= count_d;
      fire_valid_q <= fire_valid_d;
      fire_index_q <= fire_index_d;
      blink_q      <= blink_d;
      vis_q        <= vis_d;
    end
  end

  assign cur_sector = sector_q;
  assign cur_pos    = pos_q;
  assign cursor_vis = vis_q;
  assign ships      = ships_q;
  assign shots      = shots_q;
  assign ship_count = count_q;
  assign state      = state_q;
  assign fire_valid = fire_valid_q;
  assign fire_index = fire_index_q;

endmodule
